// File: rtl/rf_32.sv
// 32 x 32 MIPS register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous active-low clear of all entries.
module rf_32 #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DEPTH      = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  read_enabled,
   input  logic [ADDR_WIDTH-1:0] read_addr_s,
   input  logic [ADDR_WIDTH-1:0] read_addr_t,
   input  logic                  write_enabled,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] outA,
   output logic [DATA_WIDTH-1:0] outB
);

   logic [DATA_WIDTH-1:0] register_file [0:DEPTH-1];

   // Read strobe is reserved; outputs always follow the addresses.
   logic unused_read_enabled;
   assign unused_read_enabled = read_enabled;

   // Writes to entry 0 are dropped so it stays zero from reset onward.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            register_file[i] <= '0;
         end
      end else if (write_enabled && (write_addr != '0)) begin
         register_file[write_addr] <= write_data;
      end
   end

   // No write bypass: same-address forwarding belongs to the pipeline.
   assign outA = (read_addr_s == '0) ? '0 : register_file[read_addr_s];
   assign outB = (read_addr_t == '0) ? '0 : register_file[read_addr_t];

endmodule

// File: tb/tb_rf_32.sv
// Directed bench for rf_32: expected read data is queued from a reference model
// when addresses are driven and popped when the outputs are sampled.
module tb_rf_32;

   logic        clock;
   logic        reset_n;
   logic        read_enabled;
   logic [4:0]  read_addr_s;
   logic [4:0]  read_addr_t;
   logic        write_enabled;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] outA;
   logic [31:0] outB;

   logic [31:0] model [32];
   logic [31:0] sb [$];
   int n_assert;
   int n_fail;

   rf_32 dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .read_enabled  (read_enabled),
      .read_addr_s   (read_addr_s),
      .read_addr_t   (read_addr_t),
      .write_enabled (write_enabled),
      .write_addr    (write_addr),
      .write_data    (write_data),
      .outA          (outA),
      .outB          (outB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
      end
   endtask

   task automatic read_check(input string tag, input logic [4:0] as, input logic [4:0] at);
      read_addr_s = as;
      read_addr_t = at;
      sb.push_back(model[as]);
      sb.push_back(model[at]);
      #1;
      check($sformatf("%s_A[%0d]", tag, as), outA);
      check($sformatf("%s_B[%0d]", tag, at), outB);
   endtask

   task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
      @(negedge clock);
      write_enabled = en;
      write_addr    = a;
      write_data    = d;
      @(posedge clock);
      #1;
      if (en && a != 5'd0) model[a] = d;
      write_enabled = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   initial begin
      logic [31:0] v;
      n_assert = 0;
      n_fail   = 0;
      clear_model();
      reset_n       = 1'b0;
      read_enabled  = 1'b0;
      read_addr_s   = 5'd0;
      read_addr_t   = 5'd0;
      write_enabled = 1'b0;
      write_addr    = 5'd0;
      write_data    = 32'h0;

      // Power-on reset state
      repeat (2) @(posedge clock);
      #1;
      read_check("por", 5'd1, 5'd31);
      read_check("por", 5'd0, 5'd16);
      @(negedge clock);
      reset_n = 1'b1;

      // Full write sweep, one write per clock
      for (int a = 1; a < 32; a++) begin
         if (a <= 15)      v = 32'(a - 1) * 32'h11111111;
         else if (a == 16) v = 32'hFFFFFFFF;
         else if (a <= 30) v = 32'(a - 16);
         else              v = 32'hDEADBEEF;
         do_write(5'(a), v, 1'b1);
      end
      read_enabled = 1'b0;
      for (int a = 0; a < 32; a++) read_check("sweep_s", 5'(a), 5'd0);
      for (int a = 0; a < 32; a++) read_check("sweep_t", 5'd0, 5'(a));
      read_enabled = 1'b1;
      read_check("ren_hi", 5'd16, 5'd31);
      read_enabled = 1'b0;

      // Register zero ignores writes
      do_write(5'd0, 32'hDEADBEEF, 1'b1);
      sb.push_back(32'h0);
      check("reg0_storage", dut.register_file[0]);
      read_check("reg0", 5'd0, 5'd0);

      // Write disabled leaves state untouched
      repeat (3) do_write(5'd5, 32'h12345678, 1'b0);
      sb.push_back(32'h44444444);
      check("wdis_const", dut.register_file[5]);
      read_check("wdis", 5'd5, 5'd5);

      // Dual port and read-during-write without bypass
      read_check("dual", 5'd7, 5'd7);
      @(negedge clock);
      write_enabled = 1'b1;
      write_addr    = 5'd7;
      write_data    = 32'hCAFEF00D;
      sb.push_back(32'h66666666);
      sb.push_back(32'h66666666);
      #1;
      check("rdw_before_A", outA);
      check("rdw_before_B", outB);
      @(posedge clock);
      #1;
      model[7] = 32'hCAFEF00D;
      write_enabled = 1'b0;
      sb.push_back(32'hCAFEF00D);
      sb.push_back(32'hCAFEF00D);
      check("rdw_after_A", outA);
      check("rdw_after_B", outB);

      // Reset falling in the same cycle as a write
      read_check("pre_rst", 5'd9, 5'd8);
      @(negedge clock);
      write_enabled = 1'b1;
      write_addr    = 5'd9;
      write_data    = 32'h5A5A5A5A;
      #2;
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      clear_model();
      @(negedge clock);
      reset_n       = 1'b1;
      write_enabled = 1'b0;
      read_check("rst_vs_wr", 5'd9, 5'd9);
      do_write(5'd9, 32'h99999999, 1'b1);
      read_check("resume", 5'd9, 5'd0);
      do_write(5'd10, 32'h0BADF00D, 1'b1);
      do_write(5'd11, 32'h13572468, 1'b1);
      read_check("resume2", 5'd10, 5'd11);

      // Mid-cycle asynchronous clear, then sweep with reset held
      @(negedge clock);
      read_addr_s = 5'd10;
      read_addr_t = 5'd9;
      #2;
      reset_n = 1'b0;
      clear_model();
      sb.push_back(32'h0);
      sb.push_back(32'h0);
      #1;
      check("async_clr_A", outA);
      check("async_clr_B", outB);
      for (int a = 0; a < 32; a++) read_check("rst_sweep", 5'(a), 5'(31 - a));
      @(negedge clock);
      reset_n = 1'b1;
      read_check("post_rst", 5'd11, 5'd31);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_32.md
Name: rf_32

Overview:
32-entry x 32-bit register file for the MIPS datapath, with two read ports (rs and rt) and one write port. Reads are combinational and feed the ALU operand muxes. Writes are synchronous and driven by the writeback stage. Register 0 is hardwired to zero per MIPS convention.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, width of each address port
DEPTH, 32, number of registers (2**ADDR_WIDTH)

Ports:
clock  input  1  system clock; all writes occur on the rising edge
reset_n  input  1  reset; one clock; reset is asynchronous and active-low
read_enabled  input  1  read strobe; reserved, no functional effect (see Behaviour)
read_addr_s  input  5  rs read address
read_addr_t  input  5  rt read address
write_enabled  input  1  write strobe; active-high
write_addr  input  5  write address
write_data  input  32  write data
outA  output  32  rs read data
outB  output  32  rt read data

Behaviour:
- Storage: internal array named register_file[0:31], each entry 32 bits. The verification bench accesses this array hierarchically, so the name is fixed.
- Reset:
  - reset_n low clears all 32 entries to 32'h0 immediately, without waiting for a clock edge.
  - outA and outB therefore read 0 during reset.
  - reset_n has priority over any write in the same cycle.
- Write:
  - On a rising clock edge with reset_n high, write_enabled=1 and write_addr!=0: register_file[write_addr] <= write_data.
  - write_enabled=0 means no state change.
  - Any write to address 0 is silently discarded; entry 0 always holds 0.
- Read:
  - outA = register_file[read_addr_s] and outB = register_file[read_addr_t], purely combinational with zero-cycle latency.
  - Address 0 always returns 32'h0.
  - Both ports are independent; reading the same address on both ports is legal and returns the same value.
- read_enabled does not gate, hold or zero the outputs. Outputs track the addresses at all times.
- Read-during-write to the same address: there is no internal bypass.
  - Before the write edge, the output shows the old value.
  - After the edge, it shows write_data in the same delta as the register update.
  - Forwarding is the pipeline's job, not this block's.
- Outputs are never X once reset has been applied; all storage is defined from reset.
- Back-to-back writes on consecutive cycles to any addresses are supported, one write per cycle.

Test Plan:
1. Reset clear: assert reset_n=0 mid-cycle after prior writes; sweep read_addr_s/read_addr_t over 0..31 -> outA=outB=32'h0 for every address, taking effect immediately without a clock edge.
2. Full write sweep: with write_enabled=1, write addr 1..15 with 32'h00000000, 32'h11111111 ... 32'hEEEEEEEE; addr 16 with 32'hFFFFFFFF; addr 17..30 with 32'h1..32'hE; addr 31 with 32'hDEADBEEF, one per clock. Then read each via rs and separately via rt with read_enabled=0 -> every value returned exactly on both ports.
3. Register zero: write 32'hDEADBEEF to addr 0 -> register_file[0]==0 and outA/outB read 32'h0 at addr 0.
4. Write disable: write_enabled=0, write_addr=5, write_data=32'h12345678 for several edges -> reg 5 keeps its prior value (32'h44444444 after scenario 2).
5. Dual-port and read-during-write: read_addr_s=read_addr_t=7 -> both return 32'h66666666. Write 32'hCAFEF00D to addr 7 -> output shows 32'h66666666 before the edge and 32'hCAFEF00D after it.
6. Reset vs write: reset_n falls in the same cycle as a write to addr 9 -> reg 9 reads 0 after release; normal writes resume on the first edge with reset_n high.
